// File: rtl/io_writeback_arbiter.sv
// Round-robin arbiter sharing the single IO writeback port among the IO response sources.
// Optional macro WBARB_PORT0_PRIORITY_EN gives port 0 (clock generator) strict priority.
module io_writeback_arbiter #(
  parameter int DATABITWIDTH    = 16,
  parameter int INPUTPORTCOUNT  = 14,
  parameter int PORTADDRWIDTH   = $clog2(INPUTPORTCOUNT),
  parameter int REGADDRBITWIDTH = 4
) (
  input  logic                                             sys_clk,
  input  logic                                             async_rst_n,
  input  logic                                             clk_en,
  input  logic [INPUTPORTCOUNT-1:0]                        InputACK,
  output logic [INPUTPORTCOUNT-1:0]                        InputREQ,
  input  logic [INPUTPORTCOUNT-1:0][DATABITWIDTH-1:0]      InputData,
  input  logic [INPUTPORTCOUNT-1:0][REGADDRBITWIDTH-1:0]   InputAddr,
  output logic                                             OutputACK,
  input  logic                                             OutputREQ,
  output logic [DATABITWIDTH-1:0]                          OutputData,
  output logic [REGADDRBITWIDTH-1:0]                       OutputAddr,
  output logic [PORTADDRWIDTH-1:0]                         OutputPort
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [PORTADDRWIDTH-1:0] LAST_PORT = PORTADDRWIDTH'(INPUTPORTCOUNT - 1);

  state_t                     r_state;
  logic [PORTADDRWIDTH-1:0]   r_rr_ptr;
  logic [DATABITWIDTH-1:0]    r_data;
  logic [REGADDRBITWIDTH-1:0] r_addr;
  logic [PORTADDRWIDTH-1:0]   r_port;

  logic [PORTADDRWIDTH-1:0]   w_winner;
  logic [PORTADDRWIDTH-1:0]   w_next_ptr;
  logic                       w_found;
  logic                       w_free;
  logic                       w_grant;
  logic                       w_ptr_update;

  // The slot is free when empty or when the core drains it this same edge.
  assign w_free  = (r_state == EMPTY) || OutputREQ;
  assign w_grant = async_rst_n && clk_en && w_free && (|InputACK);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_winner = r_rr_ptr;
    w_found  = 1'b0;
    for (int k = 0; k < INPUTPORTCOUNT; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= INPUTPORTCOUNT) idx -= INPUTPORTCOUNT;
      if (!w_found && InputACK[idx]) begin
        w_winner = PORTADDRWIDTH'(idx);
        w_found  = 1'b1;
      end
    end
`ifdef WBARB_PORT0_PRIORITY_EN
    if (InputACK[0]) w_winner = '0;
`endif
  end

`ifdef WBARB_PORT0_PRIORITY_EN
  // Port-0 grants bypass the rotation, so they leave the pointer alone.
  assign w_ptr_update = w_grant && (w_winner != '0);
`else
  assign w_ptr_update = w_grant;
`endif

  assign w_next_ptr = (w_winner == LAST_PORT) ? '0 : w_winner + PORTADDRWIDTH'(1);

  always_comb begin
    InputREQ = '0;
    if (w_grant) InputREQ[w_winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state  <= EMPTY;
      r_rr_ptr <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_port   <= '0;
    end else if (clk_en) begin
      if (w_grant) begin
        r_state <= FULL;
        r_data  <= InputData[w_winner];
        r_addr  <= InputAddr[w_winner];
        r_port  <= w_winner;
        if (w_ptr_update) r_rr_ptr <= w_next_ptr;
      end else if ((r_state == FULL) && OutputREQ) begin
        // Pop without refill keeps the payload; only the valid flag drops.
        r_state <= EMPTY;
      end
    end
  end

  assign OutputACK  = (r_state == FULL);
  assign OutputData = r_data;
  assign OutputAddr = r_addr;
  assign OutputPort = r_port;

endmodule

// File: doc/io_writeback_arbiter.md
Name: io_writeback_arbiter

Overview:
- Round-robin arbiter that shares the single IO writeback port between the IO response sources: clock generator, timers and port controllers, 14 sources in the default build.
- Each source presents an ACK/REQ response carrying data and a destination register.
- The arbiter selects one source per cycle and captures it into a one-entry output register.
- It drives the core-facing WritebackACK/WritebackREQ handshake with fair, starvation-free ordering.

Parameters:
- DATABITWIDTH, 16, width of response data.
- INPUTPORTCOUNT, 14, number of response sources.
- PORTADDRWIDTH, $clog2(INPUTPORTCOUNT), width of port index / round-robin pointer.
- REGADDRBITWIDTH, 4, width of destination register field.

Ports:
- sys_clk  in  1  system clock, rising edge.
- async_rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global clock enable; state frozen when 0.
- InputACK  in  INPUTPORTCOUNT  per-source response valid.
- InputREQ  out  INPUTPORTCOUNT  per-source accept; one-hot or zero.
- InputData  in  INPUTPORTCOUNT x DATABITWIDTH  per-source response data.
- InputAddr  in  INPUTPORTCOUNT x REGADDRBITWIDTH  per-source destination register.
- OutputACK  out  1  writeback valid, registered.
- OutputREQ  in  1  core ready for writeback.
- OutputData  out  DATABITWIDTH  registered writeback data.
- OutputAddr  out  REGADDRBITWIDTH  registered destination register.
- OutputPort  out  PORTADDRWIDTH  index of the source held in the output register (debug/trace).

Behaviour:
- Handshake rules:
  - A transfer occurs on a rising edge with ACK && REQ && clk_en.
  - Sources must hold ACK, data and addr stable until accepted.
- Reset, asynchronous on async_rst_n low:
  - OutputACK=0, OutputData=0, OutputAddr=0, OutputPort=0.
  - Round-robin pointer RRPtr=0.
  - InputREQ=0 during reset.
- States: EMPTY (OutputACK=0) and FULL (OutputACK=1).
- Slot availability: Free = EMPTY || (FULL && OutputREQ). This gives a combinational path from OutputREQ to InputREQ, which is intended and gives full throughput.
- Selection:
  - Search InputACK starting at index RRPtr, ascending, wrapping at INPUTPORTCOUNT-1 to 0.
  - The first set bit is Winner.
  - Selection is purely combinational from the current InputACK and RRPtr.
- Grant: InputREQ[Winner]=1 only when Free && clk_en && |InputACK; all other bits are 0.
- Capture, on grant:
  - Next cycle OutputACK=1 with OutputData/OutputAddr/OutputPort taken from Winner.
  - RRPtr = Winner+1, wrapping to 0 after INPUTPORTCOUNT-1.
- Latency: 1 cycle from input accept to OutputACK.
- Throughput: 1 response per cycle when OutputREQ is held high.
- Pop without refill: FULL with OutputREQ=1 and no InputACK gives EMPTY next cycle. Output data is held (not cleared); RRPtr is unchanged.
- Backpressure: FULL with OutputREQ=0:
  - All InputREQ=0.
  - Output registers hold.
  - RRPtr holds.
- Simultaneous pop and grant: the output register reloads in the same edge; OutputACK stays 1.
- clk_en=0:
  - All InputREQ=0.
  - No state change, no pop.
  - OutputACK keeps its value.
- INPUTPORTCOUNT not a power of two: RRPtr never takes values >= INPUTPORTCOUNT.
- Reset mid-operation: any held response is discarded and nothing is replayed.

Optional Feature:
- Macro: WBARB_PORT0_PRIORITY_EN.
- Defined:
  - Port 0 (clock generator) has strict priority. If InputACK[0] && Free, port 0 wins regardless of RRPtr.
  - RRPtr is not updated by a port-0 grant.
  - Other ports stay round-robin among themselves.
- Undefined: all ports are pure round-robin, including port 0.

Test Plan:
- Reset with InputACK=14'h3FFF asserted -> InputREQ=0 and OutputACK=0 during reset. First grant after release is port 0; OutputPort=0 one cycle later.
- All 14 sources ACK continuously, OutputREQ=1 -> grants in order 0,1,...,13,0. One output per cycle, and each OutputData matches the source's data (source i drives 16'h1000+i).
- Ports 3 and 9 ACK, RRPtr=4 -> port 9 wins first, then port 3. OutputAddr matches each source's InputAddr.
- FULL with OutputREQ=0 for 5 cycles while port 2 ACKs -> InputREQ stays 0 and output is stable. When OutputREQ=1, pop and capture of port 2 happen on the same edge with OutputACK continuous.
- clk_en=0 for 3 cycles mid-stream -> no grants, no RRPtr change, OutputACK held. Resumes the exact sequence afterwards.
- With WBARB_PORT0_PRIORITY_EN, ports 0 and 5 ACK continuously -> port 0 granted every cycle; port 5 granted only once port 0 drops ACK.
